// File: rtl/seq_shift_add_multiplier_16.sv
// rtl/seq_shift_add_multiplier_16.sv - 16x16 unsigned shift-add multiplier around a ripple-carry adder.
// One product every 17 cycles with a start/busy/done handshake.

module ripple_carry_adder_16 (
   input  logic [15:0] in1,
   input  logic [15:0] in2,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);
   logic [16:0] c;

   assign c[0] = cin;

   genvar i;
   generate
      for (i = 0; i < 16; i++) begin : g_fa
         assign sum[i]   = in1[i] ^ in2[i] ^ c[i];
         assign c[i + 1] = (in1[i] & in2[i]) | (c[i] & (in1[i] ^ in2[i]));
      end
   endgenerate

   assign cout = c[16];
endmodule

module seq_shift_add_multiplier_16 #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   generate
      if (WIDTH != 16) begin : g_bad_width
         $error("seq_shift_add_multiplier_16: WIDTH must be 16");
      end
      if ((1 << CNT_W) <= WIDTH) begin : g_bad_cnt_w
         $error("seq_shift_add_multiplier_16: CNT_W too narrow for WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             next_state;
   logic [WIDTH-1:0]   acc_hi;
   logic [WIDTH-1:0]   q;
   logic [WIDTH-1:0]   a_reg;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   sum;
   logic               cout;
   logic               accept;
   logic               last_step;
   logic [2*WIDTH:0]   step_val;

   // Counter increment built from gates so the only adder in this block is the instance.
   function automatic logic [CNT_W-1:0] incr(input logic [CNT_W-1:0] v);
      logic c;
      c = 1'b1;
      for (int k = 0; k < CNT_W; k++) begin
         incr[k] = v[k] ^ c;
         c       = c & v[k];
      end
   endfunction

   ripple_carry_adder_16 u_adder (
      .in1  (acc_hi),
      .in2  (q[0] ? a_reg : {WIDTH{1'b0}}),
      .cin  (1'b0),
      .sum  (sum),
      .cout (cout)
   );

   assign accept    = start && (state != RUN);
   assign last_step = (cnt == CNT_W'(WIDTH - 1));
   assign step_val  = {cout, sum, q[WIDTH-1:1]};
   assign busy      = (state == RUN);
   assign done      = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = RUN;
         RUN:     if (last_step) next_state = DONE;
         DONE:    next_state = start ? RUN : IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_hi  <= '0;
         q       <= '0;
         a_reg   <= '0;
         cnt     <= '0;
         product <= '0;
      end else if (state == RUN) begin
         // cout lands in acc_hi's MSB, so the 33-bit shift never drops a carry.
         {acc_hi, q} <= step_val[2*WIDTH-1:0];
         cnt         <= incr(cnt);
         if (last_step) begin
            product <= step_val[2*WIDTH-1:0];
         end
      end else if (accept) begin
         a_reg  <= multiplicand;
         q      <= multiplier;
         acc_hi <= '0;
         cnt    <= '0;
      end
   end
endmodule

// File: tb/tb_seq_shift_add_multiplier_16.sv
// tb/tb_seq_shift_add_multiplier_16.sv - scoreboard bench for seq_shift_add_multiplier_16.
// Driver pushes expected products; a negedge monitor pops and compares on done.

module tb_seq_shift_add_multiplier_16;
   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] multiplicand;
   logic [15:0] multiplier;
   logic        busy;
   logic        done;
   logic [31:0] product;

   typedef struct {
      logic [31:0] prod;
      int          acc_cyc;
   } exp_t;

   exp_t        sb[$];
   int          cyc;
   int          checks;
   int          errors;
   int          busy_run;
   logic [31:0] held_exp;

   seq_shift_add_multiplier_16 dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every done pulse.
   always @(negedge clk) begin
      if (!rst_n) begin
         busy_run = 0;
         held_exp = 32'h0;
      end else begin
         if (busy) busy_run++;
         if (done) begin
            chk("busy_with_done", {31'h0, busy}, 32'h0);
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'h1, 32'h0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("product", product, e.prod);
               chk("latency", 32'(cyc - e.acc_cyc), 32'd16);
               chk("busy_cycles", 32'(busy_run), 32'd16);
               held_exp = e.prod;
            end
            busy_run = 0;
         end else begin
            chk("product_held", product, held_exp);
         end
      end
   end

   // Accepts immediately; caller guarantees we are at a negedge with busy=0.
   task automatic issue_now(input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      start        = 1'b1;
      multiplicand = a;
      multiplier   = b;
      @(posedge clk);
      #1;
      e.prod    = 32'(a) * 32'(b);
      e.acc_cyc = cyc;
      sb.push_back(e);
      start        = 1'b0;
      multiplicand = 16'($urandom);
      multiplier   = 16'($urandom);
   endtask

   task automatic issue(input logic [15:0] a, input logic [15:0] b);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("wait_idle_timeout", 32'h1, 32'h0);
      issue_now(a, b);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      @(negedge clk);
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!done) chk("wait_done_timeout", 32'h1, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc          = 0;
      checks       = 0;
      errors       = 0;
      busy_run     = 0;
      held_exp     = 32'h0;
      rst_n        = 1'b0;
      start        = 1'b0;
      multiplicand = 16'h0;
      multiplier   = 16'h0;
      #1;
      chk("reset_busy", {31'h0, busy}, 32'h0);
      chk("reset_done", {31'h0, done}, 32'h0);
      chk("reset_product", product, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      issue(16'd3, 16'd5);
      issue(16'hFFFF, 16'hFFFF);
      issue(16'h1234, 16'h0000);
      issue(16'h0000, 16'hABCD);

      // start while busy must be ignored
      issue(16'h00FF, 16'h0100);
      repeat (5) @(negedge clk);
      start = 1'b1; multiplicand = 16'd1; multiplier = 16'd1;
      @(posedge clk);
      #1 start = 1'b0;

      // back-to-back from the done cycle
      wait_done();
      issue(16'h0010, 16'h0010);
      wait_done();
      issue_now(16'd7, 16'd9);

      // abort mid-run with asynchronous reset
      issue(16'hD000, 16'hA000);
      repeat (8) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      sb.delete();
      chk("abort_busy", {31'h0, busy}, 32'h0);
      chk("abort_done", {31'h0, done}, 32'h0);
      chk("abort_product", product, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue(16'h000A, 16'h0003);

      for (int i = 0; i < 24; i++) begin
         logic [15:0] a;
         logic [15:0] b;
         a = 16'($urandom);
         b = 16'($urandom);
         if (i % 6 == 0) a = 16'hFFFF;
         if (i % 7 == 0) b = 16'h0000;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         issue(a, b);
      end

      begin
         int n;
         n = 0;
         while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'h0);
      end
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
